// File: rtl/data_mem_resp_if.sv
// EX/MEM to data-memory request/response bundle.
// master = pipeline side, slave = memory responder.
interface data_mem_resp_if;
    logic        mm2reg;
    logic        mwmem;
    logic [31:0] malu_out;
    logic [31:0] mqb;
    logic [31:0] mem_out;
    logic        mem_valid;
    logic        mem_stall;
    logic        misalign;

    modport master (
        output mm2reg, mwmem, malu_out, mqb,
        input  mem_out, mem_valid, mem_stall, misalign
    );

    modport slave (
        input  mm2reg, mwmem, malu_out, mqb,
        output mem_out, mem_valid, mem_stall, misalign
    );
endinterface

// File: rtl/data_mem_resp.sv
// MEM-stage word RAM with fixed multi-cycle latency and pipeline stall.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module data_mem_resp #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic         clk,
    input  logic         resetn,
    data_mem_resp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    state_t                state_n;
    logic [2:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           data_q;
    logic                  store_q;
    logic [1:0]            lo_q;
    logic [31:0]           out_q;
    logic                  valid_q;
    logic                  mis_q;
    logic                  req;
    logic                  fire;
    logic                  trap;
    logic                  unused_bits;

    logic [31:0] ram [2**DEPTH_LOG2];

    assign req  = bus.mm2reg | bus.mwmem;
    assign fire = (state == BUSY) && (cnt == 3'd0);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (req) state_n = BUSY;
            BUSY:    if (cnt == 3'd0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= 3'd0;
            out_q   <= 32'd0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            valid_q <= fire;
            mis_q   <= fire & trap;
            if (state == IDLE && req)
                cnt <= 3'(LATENCY - 1);
            else if (state == BUSY && cnt != 3'd0)
                cnt <= cnt - 3'd1;
            if (fire && !store_q && !trap)
                out_q <= ram[idx];
        end
    end

    // Request fields are only consumed in BUSY, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            idx     <= bus.malu_out[DEPTH_LOG2+1:2];
            data_q  <= bus.mqb;
            store_q <= bus.mwmem;
            lo_q    <= bus.malu_out[1:0];
        end
    end

    // Reset on the completing edge must still cancel the store.
    always_ff @(posedge clk) begin
        if (resetn && fire && store_q && !trap)
            ram[idx] <= data_q;
    end

`ifdef MISALIGN_TRAP_EN
    assign trap         = (lo_q != 2'd0);
    assign bus.misalign = mis_q;
`else
    assign trap         = 1'b0;
    assign bus.misalign = 1'b0;
`endif

    assign unused_bits = ^{bus.malu_out[31:DEPTH_LOG2+2], lo_q, mis_q};

    assign bus.mem_out   = out_q;
    assign bus.mem_valid = valid_q;
    assign bus.mem_stall = (state == IDLE && req) || (state == BUSY);
endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: directed cases plus random traffic.
// Expected responses come from a word-array model of the RAM.
module tb_data_mem_resp;
    localparam int LAT   = 2;
    localparam int DL    = 8;
    localparam int DEPTH = 1 << DL;

    typedef struct {
        logic [31:0] out;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    data_mem_resp_if bus();

    data_mem_resp #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [31:0] ram_m [DEPTH];
    logic [31:0] out_m;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every mem_valid pulse consumes one expected response.
    always @(negedge clk) begin
        if (resetn === 1'b1 && bus.mem_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid actual=1 required=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mem_out", bus.mem_out, e.out);
                check("misalign", {31'd0, bus.misalign}, {31'd0, e.mis});
            end
        end
        if (resetn === 1'b1 && bus.misalign === 1'b1 && bus.mem_valid !== 1'b1)
            check("misalign_alone", {31'd0, bus.mem_valid}, 32'd1);
    end

    function automatic logic is_trap(logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
        return addr[1:0] != 2'd0;
`else
        return 1'b0;
`endif
    endfunction

    // Model the access, then drive it like a stalled pipeline would.
    task automatic access(logic ld, logic st, logic [31:0] addr, logic [31:0] data);
        int      n;
        logic    mis;
        int      i;
        i   = int'(addr[DL+1:2]);
        mis = is_trap(addr);
        if (!mis) begin
            if (st)      ram_m[i] = data;
            else if (ld) out_m = ram_m[i];
        end
        sb.push_back('{out_m, mis});
        @(negedge clk);
        bus.mm2reg   = ld;
        bus.mwmem    = st;
        bus.malu_out = addr;
        bus.mqb      = data;
        #1;
        check("stall_on_req", {31'd0, bus.mem_stall}, 32'd1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (bus.mem_stall !== 1'b1) break;
        end
        check("stall_cycles", n, LAT + 1);
        check("valid_at_release", {31'd0, bus.mem_valid}, 32'd1);
    endtask

    task automatic idle(int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            bus.mm2reg = 1'b0;
            bus.mwmem  = 1'b0;
            #1;
            check("stall_idle", {31'd0, bus.mem_stall}, 32'd0);
        end
    endtask

    task automatic check_zero_outputs(string tag);
        check({tag, "_out"}, bus.mem_out, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.mem_valid}, 32'd0);
        check({tag, "_stall"}, {31'd0, bus.mem_stall}, 32'd0);
        check({tag, "_mis"}, {31'd0, bus.misalign}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn       = 1'b0;
        bus.mm2reg   = 1'b0;
        bus.mwmem    = 1'b0;
        bus.malu_out = 32'd0;
        bus.mqb      = 32'd0;
        out_m        = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        resetn = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            access(1'b0, 1'b1, 32'(i << 2), $urandom);
        idle(1);

        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        idle(2);
        access(1'b0, 1'b1, 32'h0, 32'h11);
        access(1'b0, 1'b1, 32'h4, 32'h22);
        access(1'b1, 1'b0, 32'h0, 32'h0);
        access(1'b1, 1'b0, 32'h4, 32'h0);
        access(1'b0, 1'b1, 32'h400, 32'hCAFE0001);
        access(1'b1, 1'b0, 32'h0, 32'h0);
        access(1'b0, 1'b1, 32'h20, 32'h99);
        access(1'b1, 1'b0, 32'h20, 32'h0);
        access(1'b1, 1'b1, 32'h8, 32'h55);
        access(1'b1, 1'b0, 32'h8, 32'h0);
        access(1'b0, 1'b1, 32'h11, 32'h77);
        access(1'b1, 1'b0, 32'h11, 32'h0);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        idle(1);

        // Reset lands on the edge that would commit the store.
        access(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5);
        @(negedge clk);
        bus.mm2reg   = 1'b0;
        bus.mwmem    = 1'b1;
        bus.malu_out = 32'h10;
        bus.mqb      = 32'h12345678;
        repeat (2) @(negedge clk);
        resetn     = 1'b0;
        bus.mwmem  = 1'b0;
        @(negedge clk);
        check_zero_outputs("abort");
        resetn = 1'b1;
        out_m  = 32'd0;
        access(1'b1, 1'b0, 32'h10, 32'h0);
        idle(1);

        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 3);
            access(r != 2, r >= 2, $urandom, $urandom);
            idle($urandom_range(0, 2));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
